// File: rtl/toy_bus_arb_node_fetch_pld_type_toybusreq.sv
// Two-to-one round-robin merge node for the toy bus request channel.
// Requests from in0/in1 are granted round-robin and written into a
// registered 2-entry buffer; out0 always presents the buffer head, so no
// input reaches out0_* through combinational logic.
module toy_bus_arb_node_fetch_pld_type_toybusreq #(
    parameter int PRIO_INIT = 0,
    parameter int DEPTH     = 2
) (
    input  logic         clk,
    input  logic         rst,
    // input 0
    input  logic         in0_vld,
    output logic         in0_rdy,
    input  logic [31:0]  in0_addr,
    input  logic [31:0]  in0_strb,
    input  logic [255:0] in0_data,
    input  logic         in0_opcode,
    input  logic [3:0]   in0_src_id,
    input  logic [3:0]   in0_tgt_id,
    input  logic [31:0]  in0_sideband,
    // input 1
    input  logic         in1_vld,
    output logic         in1_rdy,
    input  logic [31:0]  in1_addr,
    input  logic [31:0]  in1_strb,
    input  logic [255:0] in1_data,
    input  logic         in1_opcode,
    input  logic [3:0]   in1_src_id,
    input  logic [3:0]   in1_tgt_id,
    input  logic [31:0]  in1_sideband,
    // merged output
    output logic         out0_vld,
    input  logic         out0_rdy,
    output logic [31:0]  out0_addr,
    output logic [31:0]  out0_strb,
    output logic [255:0] out0_data,
    output logic         out0_opcode,
    output logic [3:0]   out0_src_id,
    output logic [3:0]   out0_tgt_id,
    output logic [31:0]  out0_sideband
);

    localparam int PLD_W = 361;

    if (DEPTH != 2) begin : g_depth_check
        $error("toy_bus_arb_node: DEPTH must be 2 in this revision");
    end
    if (PRIO_INIT != 0 && PRIO_INIT != 1) begin : g_prio_check
        $error("toy_bus_arb_node: PRIO_INIT must be 0 or 1");
    end

    logic [PLD_W-1:0] r_mem [0:1];
    logic [1:0]       r_cnt;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_prio;

    logic             w_full;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_push0;
    logic             w_push1;
    logic             w_push;
    logic             w_pop;
    logic [PLD_W-1:0] w_pld0;
    logic [PLD_W-1:0] w_pld1;
    logic [PLD_W-1:0] w_push_pld;
    logic [PLD_W-1:0] w_head;

    assign w_full = (r_cnt == 2'd2);

    // Round-robin grant: a lone requester wins, a tie goes to r_prio.
    assign w_gnt0 = in0_vld && (!in1_vld || (r_prio == 1'b0));
    assign w_gnt1 = in1_vld && (!in0_vld || (r_prio == 1'b1));

    assign in0_rdy = !rst && !w_full && w_gnt0;
    assign in1_rdy = !rst && !w_full && w_gnt1;

    assign w_push0 = in0_vld && in0_rdy;
    assign w_push1 = in1_vld && in1_rdy;
    assign w_push  = w_push0 || w_push1;
    assign w_pop   = out0_vld && out0_rdy;

    assign w_pld0 = {in0_addr, in0_strb, in0_data, in0_opcode,
                     in0_src_id, in0_tgt_id, in0_sideband};
    assign w_pld1 = {in1_addr, in1_strb, in1_data, in1_opcode,
                     in1_src_id, in1_tgt_id, in1_sideband};
    assign w_push_pld = w_push1 ? w_pld1 : w_pld0;

    // Head entry drives the output; valid is masked during reset so stale
    // entries are never presented.
    assign w_head   = r_mem[r_rd_ptr];
    assign out0_vld = !rst && (r_cnt != 2'd0);
    assign {out0_addr, out0_strb, out0_data, out0_opcode,
            out0_src_id, out0_tgt_id, out0_sideband} = w_head;

    // Payload storage: written on push only.
    // NOTE: the payload array has no reset; the pointers and counter alone
    // decide what is valid, so resetting 722 flops would buy nothing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_pld;
        end
    end

    // Control state: pointers, occupancy and round-robin priority.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_prio   <= 1'(PRIO_INIT);
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
                r_prio   <= w_push0 ? 1'b1 : 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_toy_bus_arb_node_fetch_pld_type_toybusreq.sv
// Scoreboard bench for the toy bus two-to-one merge node. The driver issues
// directed vectors and pushes each hand-predicted accepted payload into a
// queue; an independent monitor pops and compares on every out0 handshake.
module tb_toy_bus_arb_node_fetch_pld_type_toybusreq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in0_vld = 1'b0, in1_vld = 1'b0, out0_rdy = 1'b0;
    logic         in0_rdy, in1_rdy, out0_vld;
    logic [31:0]  in0_addr = '0, in0_strb = '0, in0_sideband = '0;
    logic [31:0]  in1_addr = '0, in1_strb = '0, in1_sideband = '0;
    logic [255:0] in0_data = '0, in1_data = '0;
    logic         in0_opcode = 1'b0, in1_opcode = 1'b0;
    logic [3:0]   in0_src_id = '0, in0_tgt_id = '0, in1_src_id = '0, in1_tgt_id = '0;
    logic [31:0]  out0_addr, out0_strb, out0_sideband;
    logic [255:0] out0_data;
    logic         out0_opcode;
    logic [3:0]   out0_src_id, out0_tgt_id;

    int tests = 0;
    int fails = 0;
    logic [360:0] exp_q[$];

    always #5 clk = ~clk;

    toy_bus_arb_node_fetch_pld_type_toybusreq #(.PRIO_INIT(0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_addr(in0_addr), .in0_strb(in0_strb),
        .in0_data(in0_data), .in0_opcode(in0_opcode), .in0_src_id(in0_src_id),
        .in0_tgt_id(in0_tgt_id), .in0_sideband(in0_sideband),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_addr(in1_addr), .in1_strb(in1_strb),
        .in1_data(in1_data), .in1_opcode(in1_opcode), .in1_src_id(in1_src_id),
        .in1_tgt_id(in1_tgt_id), .in1_sideband(in1_sideband),
        .out0_vld(out0_vld), .out0_rdy(out0_rdy), .out0_addr(out0_addr),
        .out0_strb(out0_strb), .out0_data(out0_data), .out0_opcode(out0_opcode),
        .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id), .out0_sideband(out0_sideband)
    );

    // Full payload derived from an address, source and target id.
    function automatic logic [360:0] make_pld(input logic [31:0] a, input logic [3:0] s,
                                              input logic [3:0] t);
        return {a, ~a, {8{a}}, a[0], s, t, a ^ 32'hA5A5_A5A5};
    endfunction

    function automatic logic [360:0] out_pld();
        return {out0_addr, out0_strb, out0_data, out0_opcode,
                out0_src_id, out0_tgt_id, out0_sideband};
    endfunction

    task automatic check(input string name, input logic [360:0] got, input logic [360:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic v1,
                         input logic [31:0] a1, input logic ordy);
        logic [360:0] p0, p1;
        p0 = make_pld(a0, 4'd0, 4'd2);
        p1 = make_pld(a1, 4'd1, 4'd3);
        in0_vld = v0;
        {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband} = p0;
        in1_vld = v1;
        {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband} = p1;
        out0_rdy = ordy;
    endtask

    // One clock cycle with hand-predicted ready values; accepted payloads
    // are queued for the monitor.
    task automatic cyc(input logic v0, input logic [31:0] a0, input logic v1,
                       input logic [31:0] a1, input logic ordy,
                       input logic er0, input logic er1);
        drive(v0, a0, v1, a1, ordy);
        if (v0 && er0) exp_q.push_back(make_pld(a0, 4'd0, 4'd2));
        if (v1 && er1) exp_q.push_back(make_pld(a1, 4'd1, 4'd3));
        @(negedge clk);
        check("in0_rdy", 361'(in0_rdy), 361'(er0));
        check("in1_rdy", 361'(in1_rdy), 361'(er1));
        @(posedge clk); #1;
    endtask

    // One reset cycle with both inputs requesting; buffered entries are lost.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 32'hBAD0, 1'b1, 32'hBAD1, 1'b1);
        exp_q.delete();
        @(negedge clk);
        check("rst_out0_vld", 361'(out0_vld), 361'(0));
        check("rst_in0_rdy", 361'(in0_rdy), 361'(0));
        check("rst_in1_rdy", 361'(in1_rdy), 361'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 0, 1'b0, 0, 1'b1);
    endtask

    // Scoreboard monitor: every out0 handshake must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (out0_vld && out0_rdy) begin
                if (exp_q.size() == 0) check("unexpected_out", out_pld(), '0);
                else check("out0_payload", out_pld(), exp_q.pop_front());
            end
        end
    end

    initial begin
        int n0, n1;
        logic g0;
        // Reset: 2 cycles, ready stays low even with requests pending.
        @(posedge clk); #1;
        do_reset();

        // Single input: 4 back-to-back requests, visible one cycle later.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h100 + i, 1'b0, 0, 1'b1, 1'b1, 1'b0);
            check("lat_vld", 361'(out0_vld), 361'(1));
            check("lat_addr", 361'(out0_addr), 361'(32'h100 + i));
        end
        cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Fairness: both valid from reset, grants alternate in0 first.
        do_reset();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            g0 = (k % 2 == 0);
            cyc(1'b1, 32'h200 + n0, 1'b1, 32'h300 + n1, 1'b1, g0, !g0);
            if (g0) n0++; else n1++;
        end
        repeat (2) cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A, B absorbed, C held until the slot frees.
        cyc(1'b0, 0, 1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Stall stability: head held for 5 cycles with out0_rdy low.
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, 1'b0, 0, 1'b0);
            @(negedge clk);
            check("stall_vld", 361'(out0_vld), 361'(1));
            check("stall_pld", out_pld(), make_pld(32'hDEAD_BEEF, 4'd0, 4'd2));
            @(posedge clk); #1;
        end
        repeat (2) cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Reset mid-traffic: fill to 2 (prio moves to in1), then reset.
        cyc(1'b1, 32'h400, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h401, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h402, 1'b1, 32'h403, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("post_rst_empty", 361'(out0_vld), 361'(0));
        cyc(1'b1, 32'h600, 1'b1, 32'h700, 1'b1, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Pointer wrap: 10 cycles, out0_rdy alternating 1/0.
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 32'h500 + k, 1'b0, 0, (k % 2 == 0), (k == 0) || (k % 2 == 1), 1'b0);
        end
        repeat (3) cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        check("sb_drained", 361'(exp_q.size()), 361'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
